// File: rtl/i2s_encoder.sv
// I2S master transmitter: 64-SCK frame, 16 data bits MSB first per channel, 16 zero pad bits.
// Optional macro I2S_LEFT_JUSTIFIED_EN selects left-justified WS timing (WS edge coincident with MSB).
module i2s_encoder #(
  parameter int SCK_HALF = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] left_in,
  input  logic [15:0] right_in,
  output logic        sample_req,
  output logic        sck,
  output logic        ws,
  output logic        sd
);

  localparam int DW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [DW-1:0] DIV_TC = DW'(SCK_HALF - 1);

  logic [DW-1:0] div_q, div_d;
  logic          sck_q, sck_d;
  logic [5:0]    b_q, b_d;
  logic          ws_q, ws_d;
  logic          sd_q, sd_d;
  logic          req_q, req_d;
  logic [15:0]   lhold_q, lhold_d;
  logic [15:0]   rhold_q, rhold_d;

  logic          tc;
  logic [5:0]    b_nxt;
  logic [3:0]    bit_idx;
  logic          ws_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      sck_q   <= 1'b0;
      b_q     <= 6'd63;
      ws_q    <= 1'b0;
      sd_q    <= 1'b0;
      req_q   <= 1'b0;
      lhold_q <= '0;
      rhold_q <= '0;
    end else begin
      div_q   <= div_d;
      sck_q   <= sck_d;
      b_q     <= b_d;
      ws_q    <= ws_d;
      sd_q    <= sd_d;
      req_q   <= req_d;
      lhold_q <= lhold_d;
      rhold_q <= rhold_d;
    end
  end

  always_comb begin
    div_d   = div_q;
    sck_d   = sck_q;
    b_d     = b_q;
    ws_d    = ws_q;
    sd_d    = sd_q;
    req_d   = 1'b0;
    lhold_d = lhold_q;
    rhold_d = rhold_q;

    tc      = (div_q == DIV_TC);
    b_nxt   = b_q + 6'd1;
    // Slots 0..15 and 32..47 both map bit 15-(b mod 16), i.e. the inverted low nibble.
    bit_idx = ~b_nxt[3:0];
`ifdef I2S_LEFT_JUSTIFIED_EN
    ws_nxt  = b_nxt[5];
`else
    ws_nxt  = (b_nxt >= 6'd31) && (b_nxt <= 6'd62);
`endif

    if (tc) begin
      div_d = '0;
      sck_d = ~sck_q;
    end else begin
      div_d = div_q + DW'(1);
    end

    if (tc && sck_q) begin
      b_d  = b_nxt;
      ws_d = ws_nxt;
      if (b_nxt == 6'd0) begin
        lhold_d = left_in;
        rhold_d = right_in;
        req_d   = 1'b1;
        sd_d    = left_in[15];
      end else if (b_nxt[4]) begin
        sd_d = 1'b0;
      end else if (b_nxt[5]) begin
        sd_d = rhold_q[bit_idx];
      end else begin
        sd_d = lhold_q[bit_idx];
      end
    end
  end

  assign sck        = sck_q;
  assign ws         = ws_q;
  assign sd         = sd_q;
  assign sample_req = req_q;

endmodule

// File: tb/tb_i2s_encoder.sv
// Scoreboard bench for i2s_encoder (SCK_HALF=2): driver queues expected sample pairs,
// monitor reassembles each 64-slot frame on SCK rising edges and compares sd/ws.
module tb_i2s_encoder;

  localparam int SH        = 2;
  localparam int NV        = 6;
  localparam int RST_FRAME = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] left_in = '0;
  logic [15:0] right_in = '0;
  logic        sample_req, sck, ws, sd;

  int vectors = 0;
  int miscompares = 0;
  int frames_done = 0;
  bit done = 1'b0;

  logic [31:0] exp_q[$];
  logic [15:0] vl[NV] = '{16'hA5C3, 16'h8000, 16'h0001, 16'h0F0F, 16'hFFFF, 16'h1234};
  logic [15:0] vr[NV] = '{16'h3C5A, 16'h7FFF, 16'hFFFE, 16'hF0F0, 16'h0000, 16'h5678};

  always #5 clk = ~clk;

  i2s_encoder #(.SCK_HALF(SH)) dut (
    .clk       (clk),
    .reset     (rst),
    .left_in   (left_in),
    .right_in  (right_in),
    .sample_req(sample_req),
    .sck       (sck),
    .ws        (ws),
    .sd        (sd)
  );

  function automatic logic [63:0] exp_sd(input logic [15:0] l, input logic [15:0] r);
    logic [63:0] v;
    v = '0;
    for (int s = 0; s < 16; s++) begin
      v[s]      = l[15-s];
      v[32 + s] = r[15-s];
    end
    return v;
  endfunction

  function automatic logic [63:0] exp_ws();
    logic [63:0] v;
    for (int s = 0; s < 64; s++) begin
`ifdef I2S_LEFT_JUSTIFIED_EN
      v[s] = (s >= 32);
`else
      v[s] = (s >= 31) && (s <= 62);
`endif
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (sample_req === 1'b1) break;
      if (n >= 400) begin
        check("sample_req timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  task automatic push(input int i);
    left_in  = vl[i];
    right_in = vr[i];
    exp_q.push_back({vl[i], vr[i]});
  endtask

  // Monitor: frame reassembly, WS edge alignment, sample_req interval
  initial begin : monitor
    logic [31:0] cur;
    logic [63:0] got_sd, got_ws;
    int slot, cyc, last_req;
    bit collecting, last_ok, sck_prev, ws_prev;
    collecting = 0; last_ok = 0; sck_prev = 0; ws_prev = 0;
    slot = 0; cyc = 0; last_req = 0; cur = '0; got_sd = '0; got_ws = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst) begin
        collecting = 0;
        last_ok = 0;
      end else begin
        if (ws !== ws_prev)
          check("ws changes only on sck fall", {62'd0, sck_prev, sck}, 64'd2);
        if (sample_req && !done) begin
          if (last_ok) check("sample_req interval", 64'(cyc - last_req), 64'(128 * SH));
          last_req = cyc;
          last_ok  = 1;
          if (exp_q.size() == 0) begin
            check("expected queue underflow", 64'd0, 64'd1);
            collecting = 0;
          end else begin
            cur = exp_q.pop_front();
            collecting = 1;
            slot = 0;
          end
        end
        if (collecting && sck && !sck_prev) begin
          got_sd[slot] = sd;
          got_ws[slot] = ws;
          slot++;
          if (slot == 64) begin
            check("sd frame", got_sd, exp_sd(cur[31:16], cur[15:0]));
            check("ws frame", got_ws, exp_ws());
            frames_done++;
            collecting = 0;
          end
        end
      end
      sck_prev = sck;
      ws_prev  = ws;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int n;
    push(0);
    repeat (3) @(posedge clk);
    #1;
    check("reset sck/ws/sd/req", {60'd0, sck, ws, sd, sample_req}, 64'd0);
    #1 rst = 1'b0;
    wait_req(n);
    check("first sample_req latency", 64'(n), 64'(2 * SH));

    for (int i = 0; i < NV - 1; i++) begin
      // change inputs at slot 10; the running frame must keep its latched pair
      repeat (40) @(posedge clk);
      #2 push(i + 1);
      if (i == RST_FRAME) begin
        repeat (122) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid-frame reset sck", {63'd0, sck}, 64'd0);
        check("mid-frame reset ws", {63'd0, ws}, 64'd0);
        check("mid-frame reset sd", {63'd0, sd}, 64'd0);
        check("mid-frame reset req", {63'd0, sample_req}, 64'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        wait_req(n);
        check("sample_req latency after reset", 64'(n), 64'(2 * SH));
      end else begin
        wait_req(n);
      end
    end

    repeat (255) @(posedge clk);
    #2 done = 1'b1;
    check("frames checked", 64'(frames_done), 64'(NV - 1));
    check("expected queue drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
